pfiform_lane_serializer: RTL and testbench



---
 rtl/pfiform_lane_serializer.sv | 117 +++++++++++
 tb/tb_pfiform_lane_serializer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pfiform_lane_serializer.sv
// Byte serializer behind the PFIFORM packing FIFO: unpacks 96-bit words of 1-12 lanes
// onto a valid/ready byte stream, LSB lane first, and tracks fixed-length frames.
module pfiform_lane_serializer #(
    parameter int LANE_W    = 8,
    parameter int LANES     = 12,
    parameter int FRAME_LEN = 1024,
    parameter int FCNT_W    = 16
) (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rst,
    input  logic                      PopEnable,
    input  logic [LANE_W*LANES-1:0]   PopData,
    output logic                      PopPermit,
    input  logic [3:0]                i_pop_amount,
    output logic [LANE_W-1:0]         o_byte,
    output logic                      o_byte_valid,
    input  logic                      i_byte_ready,
    output logic                      o_byte_last,
    output logic [FCNT_W-1:0]         o_frame_cnt
);

    localparam int AMT_W = 4;
    localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [LANE_W*LANES-1:0]   word_q, word_d;
    logic [AMT_W-1:0]          amt_q, amt_d;
    logic [AMT_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          bcnt_q, bcnt_d;
    logic [FCNT_W-1:0]         fcnt_q, fcnt_d;

    logic                      last_lane;
    logic                      frame_end;
    logic                      word_xfer;
    logic                      byte_xfer;

    // Amounts of 0 or above the lane count mean "full word".
    function automatic logic [AMT_W-1:0] clamp_amount(input logic [AMT_W-1:0] a);
        if (a == '0 || int'(a) > LANES) begin
            return AMT_W'(LANES);
        end
        return a;
    endfunction

    assign last_lane    = (idx_q == amt_q - AMT_W'(1));
    assign frame_end    = (bcnt_q == CNT_W'(FRAME_LEN - 1));
    assign o_byte_valid = (state_q == S_SHIFT);
    assign o_byte_last  = o_byte_valid && frame_end;
    assign o_frame_cnt  = fcnt_q;
    assign o_byte       = o_byte_valid ? word_q[idx_q*LANE_W +: LANE_W] : '0;

    // Accepting on the final lane while it drains keeps words back-to-back without a bubble.
    assign PopPermit = !i_rx_rst &&
                       ((state_q == S_IDLE) ||
                        (state_q == S_SHIFT && last_lane && i_byte_ready));

    assign word_xfer = PopEnable && PopPermit;
    assign byte_xfer = o_byte_valid && i_byte_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        amt_d   = amt_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        fcnt_d  = fcnt_q;

        if (byte_xfer) begin
            if (last_lane) begin
                state_d = S_IDLE;
            end else begin
                idx_d = idx_q + AMT_W'(1);
            end
            if (frame_end) begin
                bcnt_d = '0;
                fcnt_d = fcnt_q + FCNT_W'(1);
            end else begin
                bcnt_d = bcnt_q + CNT_W'(1);
            end
        end

        // A load overrides the drain-to-idle decision taken above.
        if (word_xfer) begin
            state_d = S_SHIFT;
            word_d  = PopData;
            amt_d   = clamp_amount(i_pop_amount);
            idx_d   = '0;
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state_q <= S_IDLE;
            amt_q   <= AMT_W'(LANES);
            idx_q   <= '0;
            bcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            amt_q   <= amt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // The held word is pure data; o_byte is masked while nothing valid is held.
    always_ff @(posedge i_core_clk) begin
        word_q <= word_d;
    end

endmodule

// File: tb/tb_pfiform_lane_serializer.sv
// Randomized bench for pfiform_lane_serializer; the reference is a byte queue plus a
// running byte total from which frame position and frame count are derived.
module tb_pfiform_lane_serializer;

    localparam int LANE_W    = 8;
    localparam int LANES     = 12;
    localparam int FRAME_LEN = 16;
    localparam int FCNT_W    = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    pop_enable;
    logic [LANE_W*LANES-1:0] pop_data;
    logic                    pop_permit;
    logic [3:0]              pop_amount;
    logic [LANE_W-1:0]       o_byte;
    logic                    o_byte_valid;
    logic                    byte_ready;
    logic                    o_byte_last;
    logic [FCNT_W-1:0]       o_frame_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    longint      total_bytes = 0;

    always #5 clk = ~clk;

    pfiform_lane_serializer #(
        .LANE_W   (LANE_W),
        .LANES    (LANES),
        .FRAME_LEN(FRAME_LEN),
        .FCNT_W   (FCNT_W)
    ) dut (
        .i_core_clk  (clk),
        .i_rx_rst    (rst),
        .PopEnable   (pop_enable),
        .PopData     (pop_data),
        .PopPermit   (pop_permit),
        .i_pop_amount(pop_amount),
        .o_byte      (o_byte),
        .o_byte_valid(o_byte_valid),
        .i_byte_ready(byte_ready),
        .o_byte_last (o_byte_last),
        .o_frame_cnt (o_frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff_amount(input logic [3:0] a);
        if (a == 4'd0 || int'(a) > LANES) return LANES;
        return int'(a);
    endfunction

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic        exp_valid;
        logic        exp_permit;
        logic        exp_last;
        logic [15:0] exp_fcnt;
        logic        wx;
        logic        bx;
        @(negedge clk);
        exp_valid  = (exp_q.size() > 0);
        exp_permit = !rst && ((exp_q.size() == 0) || (exp_q.size() == 1 && byte_ready));
        exp_last   = exp_valid && ((total_bytes % FRAME_LEN) == FRAME_LEN - 1);
        exp_fcnt   = 16'(total_bytes / FRAME_LEN);
        chk("valid", 32'(o_byte_valid), 32'(exp_valid));
        chk("permit", 32'(pop_permit), 32'(exp_permit));
        chk("last", 32'(o_byte_last), 32'(exp_last));
        chk("frame_cnt", 32'(o_frame_cnt), 32'(exp_fcnt));
        if (exp_valid) chk("byte", 32'(o_byte), 32'(exp_q[0]));
        else if (rst) chk("byte_rst", 32'(o_byte), 32'd0);
        wx = pop_enable && exp_permit;
        bx = exp_valid && byte_ready;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            total_bytes = 0;
        end else begin
            if (bx) begin
                void'(exp_q.pop_front());
                total_bytes++;
            end
            if (wx) begin
                for (int i = 0; i < eff_amount(pop_amount); i++) begin
                    exp_q.push_back(pop_data[8*i +: 8]);
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic pe, input logic [3:0] amt, input logic rdy, input logic rs,
                         input int n);
        for (int k = 0; k < n; k++) begin
            pop_enable = pe;
            pop_amount = amt;
            byte_ready = rdy;
            rst        = rs;
            pop_data   = {$urandom, $urandom, $urandom};
            cycle();
        end
    endtask

    initial begin
        rst        = 1'b1;
        pop_enable = 1'b1;
        pop_amount = 4'd5;
        byte_ready = 1'b1;
        pop_data   = '0;

        drive(1'b1, 4'd5, 1'b1, 1'b1, 3);
        drive(1'b0, 4'd5, 1'b1, 1'b0, 1);

        // Single word, lanes hold their own index, 11 of 12 emitted.
        pop_enable = 1'b1;
        pop_amount = 4'd11;
        for (int i = 0; i < LANES; i++) pop_data[8*i +: 8] = 8'(i);
        cycle();
        drive(1'b0, 4'd11, 1'b1, 1'b0, 12);

        drive(1'b1, 4'd6, 1'b1, 1'b0, 13);
        drive(1'b0, 4'd6, 1'b1, 1'b0, 8);

        // Stall on lane 2 of a four-lane word.
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1);
        drive(1'b0, 4'd4, 1'b1, 1'b0, 2);
        drive(1'b0, 4'd4, 1'b0, 1'b0, 5);
        drive(1'b0, 4'd4, 1'b1, 1'b0, 4);

        drive(1'b0, 4'd6, 1'b1, 1'b1, 1);
        drive(1'b1, 4'd6, 1'b1, 1'b0, 60);
        drive(1'b0, 4'd6, 1'b1, 1'b0, 8);

        drive(1'b1, 4'd0, 1'b1, 1'b0, 1);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 13);
        drive(1'b1, 4'd1, 1'b1, 1'b0, 10);

        // Reset while lane 5 is on the output.
        drive(1'b1, 4'd12, 1'b1, 1'b0, 1);
        drive(1'b0, 4'd12, 1'b1, 1'b0, 5);
        drive(1'b0, 4'd12, 1'b1, 1'b1, 1);
        drive(1'b1, 4'd8, 1'b1, 1'b0, 1);
        drive(1'b0, 4'd8, 1'b1, 1'b0, 10);

        for (int k = 0; k < 4000; k++) begin
            pop_enable = ($urandom_range(0, 3) != 0);
            pop_amount = 4'($urandom_range(0, 15));
            byte_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 499) == 0);
            pop_data   = {$urandom, $urandom, $urandom};
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
